// File: rtl/ltpi_sched_pkg.sv
// Shared types and helpers for the LTPI TX frame-slot scheduler.
package ltpi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SLOT = 2'd1,
    BUSY      = 2'd2
  } sched_state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ltpi_rr_picker.sv
// Round-robin find-first: lowest set req bit at or above rr_ptr, else lowest set bit overall.
module ltpi_rr_picker
  import ltpi_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] w_masked;
  logic [IDX_W-1:0]   w_idx_m;
  logic [IDX_W-1:0]   w_idx_u;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign w_masked[gi] = req[gi] && (IDX_W'(gi) >= rr_ptr);
      assign onehot[gi]   = found && (idx == IDX_W'(gi));
    end
  endgenerate

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    w_idx_m = '0;
    w_idx_u = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_masked[i]) w_idx_m = IDX_W'(i);
      if (req[i])      w_idx_u = IDX_W'(i);
    end
  end

  assign found = |req;
  assign idx   = (|w_masked) ? w_idx_m : w_idx_u;

endmodule

// File: rtl/ltpi_tx_frame_scheduler.sv
// Chooses default I/O frame or a round-robin data channel for each formatter slot;
// forces a default frame after DEF_EVERY data frames and aborts stalled frames.
module ltpi_tx_frame_scheduler
  import ltpi_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DEF_EVERY = 2,
  parameter int TIMEOUT   = 255,
  parameter int IDX_W     = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               link_aligned,
  input  logic               slot_req,
  input  logic               frame_done,
  input  logic [NUM_REQ-1:0] req,
  input  logic               err_clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               sel_valid,
  output logic               sel_default,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               busy,
  output logic               timeout_err,
  output logic               overlap_err
);

  localparam int CNT_W = $clog2(DEF_EVERY + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  sched_state_t       r_state, w_state_next;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_next;
  logic [CNT_W-1:0]   r_nondef_cnt, w_cnt_next;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic               r_sel_valid, w_valid_next;
  logic               r_sel_default, w_def_next;
  logic [IDX_W-1:0]   r_sel_idx, w_idx_next;
  logic               r_busy, w_busy_next;
  logic               r_timeout_err, w_terr_next;
  logic               r_overlap_err, w_oerr_next;
  logic               w_decide;

  logic               w_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [NUM_REQ-1:0] w_pick_onehot;

  ltpi_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .found  (w_found),
    .idx    (w_pick_idx),
    .onehot (w_pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_nondef_cnt  <= '0;
      r_tmo_cnt     <= '0;
      r_gnt         <= '0;
      r_sel_valid   <= 1'b0;
      r_sel_default <= 1'b0;
      r_sel_idx     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_rr_ptr      <= w_rr_next;
      r_nondef_cnt  <= w_cnt_next;
      r_tmo_cnt     <= w_tmo_next;
      r_gnt         <= w_gnt_next;
      r_sel_valid   <= w_valid_next;
      r_sel_default <= w_def_next;
      r_sel_idx     <= w_idx_next;
      r_busy        <= w_busy_next;
      r_timeout_err <= w_terr_next;
      r_overlap_err <= w_oerr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rr_next    = r_rr_ptr;
    w_cnt_next   = r_nondef_cnt;
    w_tmo_next   = r_tmo_cnt;
    w_gnt_next   = '0;
    w_valid_next = 1'b0;
    w_def_next   = 1'b0;
    w_idx_next   = r_sel_idx;
    w_busy_next  = r_busy;
    // Error sets below are applied after the clear, so a coincident set wins.
    w_terr_next  = r_timeout_err & ~err_clr;
    w_oerr_next  = r_overlap_err & ~err_clr;
    w_decide     = 1'b0;

    if (!link_aligned) begin
      w_state_next = IDLE;
      w_rr_next    = '0;
      w_cnt_next   = '0;
      w_tmo_next   = '0;
      w_busy_next  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_next = WAIT_SLOT;
          w_busy_next  = 1'b0;
        end
        WAIT_SLOT: w_decide = slot_req;
        BUSY: begin
          if (frame_done && slot_req) begin
            w_decide = 1'b1;
          end else if (frame_done) begin
            w_state_next = WAIT_SLOT;
            w_busy_next  = 1'b0;
          end else begin
            if (slot_req) w_oerr_next = 1'b1;
            if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
              w_terr_next  = 1'b1;
              w_busy_next  = 1'b0;
              w_state_next = WAIT_SLOT;
            end else begin
              w_tmo_next = r_tmo_cnt + TMO_W'(1);
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end

    if (w_decide) begin
      w_state_next = BUSY;
      w_busy_next  = 1'b1;
      w_tmo_next   = '0;
      w_valid_next = 1'b1;
      if (!w_found || (r_nondef_cnt == CNT_W'(DEF_EVERY))) begin
        w_def_next = 1'b1;
        w_cnt_next = '0;
      end else begin
        w_gnt_next = w_pick_onehot;
        w_idx_next = w_pick_idx;
        w_rr_next  = (w_pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + IDX_W'(1);
        w_cnt_next = r_nondef_cnt + CNT_W'(1);
      end
    end
  end

  assign gnt         = r_gnt;
  assign sel_valid   = r_sel_valid;
  assign sel_default = r_sel_default;
  assign sel_idx     = r_sel_idx;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign overlap_err = r_overlap_err;

endmodule

// File: tb/tb_ltpi_tx_frame_scheduler.sv
// Self-checking bench: decision table plus hand-written back-to-back, overlap, timeout and link-drop sequences.
module tb_ltpi_tx_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       link_aligned = 1'b1;
  logic       slot_req = 1'b0;
  logic       frame_done = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       err_clr = 1'b0;
  logic [3:0] gnt;
  logic       sel_valid;
  logic       sel_default;
  logic [1:0] sel_idx;
  logic       busy;
  logic       timeout_err;
  logic       overlap_err;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] req;
    logic       exp_def;
    logic [1:0] exp_idx;
  } vec_t;

  typedef struct {
    logic       def;
    logic [1:0] idx;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];

  always #5 clk = ~clk;

  ltpi_tx_frame_scheduler #(.NUM_REQ(4), .DEF_EVERY(2), .TIMEOUT(255)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .link_aligned (link_aligned),
    .slot_req     (slot_req),
    .frame_done   (frame_done),
    .req          (req),
    .err_clr      (err_clr),
    .gnt          (gnt),
    .sel_valid    (sel_valid),
    .sel_default  (sel_default),
    .sel_idx      (sel_idx),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overlap_err  (overlap_err)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  // Any decision pulse is matched against the oldest scoreboard entry.
  task automatic step();
    exp_t       e;
    logic [3:0] eg;
    @(posedge clk);
    #1;
    if (sel_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_sel_valid", 16'(sel_valid), 16'h0);
      end else begin
        e  = sb.pop_front();
        eg = e.def ? 4'b0000 : (4'b0001 << e.idx);
        check("sel_default", 16'(sel_default), 16'(e.def));
        check("gnt", 16'(gnt), 16'(eg));
        if (!e.def) check("sel_idx", 16'(sel_idx), 16'(e.idx));
      end
    end
  endtask

  task automatic do_slot(input logic [3:0] r, input logic d, input logic [1:0] i, input logic with_done);
    exp_t e;
    e.def = d;
    e.idx = i;
    req = r;
    sb.push_back(e);
    slot_req = 1'b1;
    step();
    slot_req = 1'b0;
    check("slot_latency", 16'({sel_valid, busy}), 16'b11);
    if (with_done) begin
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    link_aligned = 1'b1;
    req = 4'b0000;
    repeat (3) step();
    check("reset_outputs",
          16'({gnt, sel_valid, sel_default, sel_idx, busy, timeout_err, overlap_err}), 16'h0);
    reset_n = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    vecs[0]  = '{4'b0000, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 1'b0, 2'd0};
    vecs[2]  = '{4'b1111, 1'b0, 2'd1};
    vecs[3]  = '{4'b1111, 1'b1, 2'd0};
    vecs[4]  = '{4'b1111, 1'b0, 2'd2};
    vecs[5]  = '{4'b1111, 1'b0, 2'd3};
    vecs[6]  = '{4'b1111, 1'b1, 2'd0};
    vecs[7]  = '{4'b0100, 1'b0, 2'd2};
    vecs[8]  = '{4'b0100, 1'b0, 2'd2};
    vecs[9]  = '{4'b0100, 1'b1, 2'd0};
    vecs[10] = '{4'b0100, 1'b0, 2'd2};
    vecs[11] = '{4'b0100, 1'b0, 2'd2};
    vecs[12] = '{4'b1010, 1'b1, 2'd0};
    vecs[13] = '{4'b1010, 1'b0, 2'd3};
    vecs[14] = '{4'b1010, 1'b0, 2'd1};

    do_reset();

    for (int v = 0; v < 15; v++) begin
      do_slot(vecs[v].req, vecs[v].exp_def, vecs[v].exp_idx, 1'b1);
    end

    // Back-to-back: frame_done and slot_req together keep BUSY with no gap.
    do_slot(4'b1111, 1'b1, 2'd0, 1'b0);
    begin
      exp_t e;
      e.def = 1'b0;
      e.idx = 2'd2;
      sb.push_back(e);
    end
    frame_done = 1'b1;
    slot_req = 1'b1;
    step();
    frame_done = 1'b0;
    slot_req = 1'b0;
    check("b2b_valid_busy_ovl", 16'({sel_valid, busy, overlap_err}), 16'b110);

    // Overlap: slot_req while BUSY without frame_done is dropped and flagged.
    slot_req = 1'b1;
    step();
    slot_req = 1'b0;
    check("overlap_set", 16'({sel_valid, busy, overlap_err}), 16'b011);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("overlap_clr", 16'(overlap_err), 16'h0);
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
    check("done_to_wait", 16'(busy), 16'h0);

    // Timeout: busy holds for exactly 255 cycles, then drops with the sticky flag.
    do_slot(4'b1111, 1'b0, 2'd3, 1'b0);
    repeat (254) step();
    check("tmo_last_busy", 16'({busy, timeout_err}), 16'b10);
    step();
    check("tmo_fired", 16'({busy, timeout_err}), 16'b01);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("tmo_clr", 16'(timeout_err), 16'h0);

    // Link drop mid-BUSY: pointer and counter restart, sticky flag survives.
    do_reset();
    do_slot(4'b1111, 1'b0, 2'd0, 1'b1);
    do_slot(4'b1111, 1'b0, 2'd1, 1'b0);
    slot_req = 1'b1;
    step();
    slot_req = 1'b0;
    link_aligned = 1'b0;
    step();
    check("link_drop", 16'({busy, sel_valid, overlap_err}), 16'b001);
    link_aligned = 1'b1;
    repeat (2) step();
    do_slot(4'b1111, 1'b0, 2'd0, 1'b1);

    check("scoreboard_empty", 16'(sb.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
